// File: rtl/ts_pkt_arb.sv
// Packet-atomic round-robin arbiter for SRC_NUM MPEG-TS byte streams.
// One source is granted per packet; 188-byte framing is enforced on the
// output, malformed packets raise err_len and silent sources raise err_to.
module ts_pkt_arb #(
  parameter int unsigned SRC_NUM = 4,
  parameter int unsigned PKT_GAP = 2,
  parameter int unsigned SYNC_TO = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SRC_NUM-1:0]   src_req,
  output logic [SRC_NUM-1:0]   src_gnt,
  input  logic [SRC_NUM-1:0]   src_sync,
  input  logic [SRC_NUM-1:0]   src_valid,
  input  logic [SRC_NUM-1:0]   src_eop,
  input  logic [8*SRC_NUM-1:0] src_data,
  output logic                 ts_sync,
  output logic                 ts_valid,
  output logic                 ts_eop,
  output logic [7:0]           ts_data,
  output logic [2:0]           cur_src,
  output logic                 err_len,
  output logic                 err_to,
  output logic [15:0]          pkt_cnt
);

  localparam logic [7:0]  PktLen   = 8'd188;
  localparam logic [15:0] SyncLast = 16'(SYNC_TO - 1);
  // A zero gap still spends one clock in StGap.
  localparam logic [7:0]  GapLast  = (PKT_GAP == 0) ? 8'd0 : 8'(PKT_GAP - 1);

  typedef enum logic [2:0] {StIdle, StWsync, StXfer, StDrain, StGap} state_e;

  state_e               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [2:0]           cur_src_q, cur_src_d;
  logic [SRC_NUM-1:0]   gnt_q, gnt_d;
  logic [15:0]          wait_q, wait_d;
  logic [7:0]           byte_q, byte_d;
  logic [7:0]           gap_q, gap_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;
  logic                 ts_sync_q, ts_sync_d;
  logic                 ts_valid_q, ts_valid_d;
  logic                 ts_eop_q, ts_eop_d;
  logic [7:0]           ts_data_q, ts_data_d;
  logic                 err_len_q, err_len_d;
  logic                 err_to_q, err_to_d;

  logic                 sel_valid, sel_sync, sel_eop;
  logic [7:0]           sel_data;
  logic                 hi_hit, lo_hit, req_hit;
  logic [2:0]           hi_idx, lo_idx, req_idx;
  logic [SRC_NUM-1:0]   req_onehot;
  logic [7:0]           byte_nxt;

  // Mux the lane of the currently granted source.
  always_comb begin
    sel_valid = 1'b0;
    sel_sync  = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (cur_src_q == 3'(i)) begin
        sel_valid = src_valid[i];
        sel_sync  = src_sync[i];
        sel_eop   = src_eop[i];
        sel_data  = src_data[8*i +: 8];
      end
    end
  end

  // Round-robin search: first requester above the pointer, else first at/below it.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = 3'd0;
    lo_idx = 3'd0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (src_req[i]) begin
        if (3'(i) > ptr_q) begin
          if (!hi_hit) begin
            hi_hit = 1'b1;
            hi_idx = 3'(i);
          end
        end else if (!lo_hit) begin
          lo_hit = 1'b1;
          lo_idx = 3'(i);
        end
      end
    end
    req_hit = hi_hit | lo_hit;
    req_idx = hi_hit ? hi_idx : lo_idx;
    for (int i = 0; i < SRC_NUM; i++) begin
      req_onehot[i] = (req_idx == 3'(i));
    end
  end

  assign byte_nxt = byte_q + 8'd1;

  // Next-state, grant and registered-output computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_src_d  = cur_src_q;
    gnt_d      = gnt_q;
    wait_d     = wait_q;
    byte_d     = byte_q;
    gap_d      = gap_q;
    pkt_cnt_d  = pkt_cnt_q;
    ts_sync_d  = 1'b0;
    ts_valid_d = 1'b0;
    ts_eop_d   = 1'b0;
    ts_data_d  = 8'h00;
    err_len_d  = 1'b0;
    err_to_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_hit) begin
          ptr_d     = req_idx;
          cur_src_d = req_idx;
          gnt_d     = req_onehot;
          wait_d    = 16'd0;
          state_d   = StWsync;
        end
      end
      StWsync: begin
        if (sel_valid && sel_sync) begin
          ts_valid_d = 1'b1;
          ts_sync_d  = 1'b1;
          ts_data_d  = sel_data;
          byte_d     = 8'd1;
          state_d    = StXfer;
        end else if (wait_q == SyncLast) begin
          // Pointer stays on the silent source so it ranks last next round.
          err_to_d = 1'b1;
          gnt_d    = '0;
          gap_d    = 8'd0;
          state_d  = StGap;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StXfer: begin
        if (sel_valid) begin
          ts_valid_d = 1'b1;
          ts_data_d  = sel_data;
          byte_d     = byte_nxt;
          if (byte_nxt == PktLen) begin
            ts_eop_d  = 1'b1;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (sel_eop) begin
              gnt_d   = '0;
              gap_d   = 8'd0;
              state_d = StGap;
            end else begin
              err_len_d = 1'b1;
              state_d   = StDrain;
            end
          end else if (sel_eop) begin
            ts_eop_d  = 1'b1;
            err_len_d = 1'b1;
            gnt_d     = '0;
            gap_d     = 8'd0;
            state_d   = StGap;
          end
        end
      end
      StDrain: begin
        if (sel_valid && sel_eop) begin
          gnt_d   = '0;
          gap_d   = 8'd0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q >= GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= 3'(SRC_NUM - 1);
      cur_src_q  <= 3'd0;
      gnt_q      <= '0;
      wait_q     <= 16'd0;
      byte_q     <= 8'd0;
      gap_q      <= 8'd0;
      pkt_cnt_q  <= 16'd0;
      ts_sync_q  <= 1'b0;
      ts_valid_q <= 1'b0;
      ts_eop_q   <= 1'b0;
      ts_data_q  <= 8'h00;
      err_len_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_src_q  <= cur_src_d;
      gnt_q      <= gnt_d;
      wait_q     <= wait_d;
      byte_q     <= byte_d;
      gap_q      <= gap_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ts_sync_q  <= ts_sync_d;
      ts_valid_q <= ts_valid_d;
      ts_eop_q   <= ts_eop_d;
      ts_data_q  <= ts_data_d;
      err_len_q  <= err_len_d;
      err_to_q   <= err_to_d;
    end
  end

  assign src_gnt  = gnt_q;
  assign ts_sync  = ts_sync_q;
  assign ts_valid = ts_valid_q;
  assign ts_eop   = ts_eop_q;
  assign ts_data  = ts_data_q;
  assign cur_src  = cur_src_q;
  assign err_len  = err_len_q;
  assign err_to   = err_to_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_ts_pkt_arb.sv
// Randomized bench for ts_pkt_arb: sources play per-packet byte plans, and a
// packet-level reference predicts every output cycle from those plans.
module tb_ts_pkt_arb;

  localparam int NS  = 4;
  localparam int GAP = 2;
  localparam int STO = 16;
  localparam int GAP_CLKS = (GAP == 0) ? 1 : GAP;

  localparam int K_OK = 0, K_SHORT = 1, K_LONG = 2, K_TO = 3, K_100 = 4, K_200 = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   src_req, src_gnt, src_sync, src_valid, src_eop;
  logic [8*NS-1:0] src_data;
  logic            ts_sync, ts_valid, ts_eop, err_len, err_to;
  logic [7:0]      ts_data;
  logic [2:0]      cur_src;
  logic [15:0]     pkt_cnt;

  always #5 clk = ~clk;

  ts_pkt_arb #(.SRC_NUM(NS), .PKT_GAP(GAP), .SYNC_TO(STO)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_req(src_req), .src_gnt(src_gnt),
    .src_sync(src_sync), .src_valid(src_valid), .src_eop(src_eop), .src_data(src_data),
    .ts_sync(ts_sync), .ts_valid(ts_valid), .ts_eop(ts_eop), .ts_data(ts_data),
    .cur_src(cur_src), .err_len(err_len), .err_to(err_to), .pkt_cnt(pkt_cnt)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-source packet plans: optional junk bytes, then sync byte at p_s, eop at p_e.
  logic [7:0] p_data [NS][256];
  bit         p_sync [NS][256];
  bit         p_eop  [NS][256];
  int p_tot[NS], p_s[NS], p_e[NS], pos[NS], npend[NS], kidx[NS];
  int kind_tab[NS][8];

  // Reference state
  int m_gnt, m_ptr, m_cur, m_wait, m_gap;
  bit m_synced;
  logic [15:0] m_pkt;
  logic [NS-1:0] d_req;
  int d_j;
  logic [NS-1:0] prev_gnt;
  int ord_q[$], exp_ord[$];
  int cnt_len, cnt_to;

  task automatic gen_plan(input int i);
    int kind, pre, len;
    kind = kind_tab[i][kidx[i]];
    pre  = (kind == K_TO) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
    for (int j = 0; j < pre; j++) begin
      p_data[i][j] = 8'($urandom);
      p_sync[i][j] = 1'b0;
      p_eop[i][j]  = 1'($urandom);
    end
    p_s[i] = pre;
    case (kind)
      K_SHORT: len = $urandom_range(2, 187);
      K_LONG:  len = $urandom_range(189, 230);
      K_100:   len = 100;
      K_200:   len = 200;
      default: len = 188;
    endcase
    if (kind == K_TO) begin
      p_s[i] = 256;
      p_e[i] = -1;
      p_tot[i] = pre;
    end else begin
      for (int j = pre; j < pre + len; j++) begin
        p_data[i][j] = (j == pre) ? 8'h47 : 8'($urandom);
        p_sync[i][j] = (j == pre) || ($urandom_range(0, 15) == 0);
        p_eop[i][j]  = (j == pre + len - 1);
      end
      p_e[i] = pre + len - 1;
      p_tot[i] = pre + len;
    end
    pos[i] = 0;
  endtask

  task automatic set_src(input int i, input int n, input int kind);
    npend[i] = n;
    kidx[i] = 0;
    for (int k = 0; k < n; k++) kind_tab[i][k] = kind;
    if (n > 0) gen_plan(i);
  endtask

  task automatic end_grant(input int g);
    m_gnt = -1;
    m_gap = GAP_CLKS;
    npend[g]--;
    kidx[g]++;
    if (npend[g] > 0) gen_plan(g);
  endtask

  // Sources react to the reference grant; non-granted lanes carry noise.
  task automatic drive();
    d_j = -1;
    for (int i = 0; i < NS; i++) begin
      src_req[i] = (npend[i] > 0);
      if (m_gnt == i && pos[i] < p_tot[i] && (pos[i] <= p_s[i] || $urandom_range(0, 3) != 0)) begin
        src_valid[i]       = 1'b1;
        src_sync[i]        = p_sync[i][pos[i]];
        src_eop[i]         = p_eop[i][pos[i]];
        src_data[8*i +: 8] = p_data[i][pos[i]];
        d_j = pos[i];
        pos[i]++;
      end else begin
        src_valid[i]       = (m_gnt != i) ? 1'($urandom) : 1'b0;
        src_sync[i]        = 1'($urandom);
        src_eop[i]         = 1'($urandom);
        src_data[8*i +: 8] = 8'($urandom);
      end
    end
    d_req = src_req;
  endtask

  task automatic step();
    int g, j, n;
    bit e_sync, e_valid, e_eop, e_len, e_to;
    logic [7:0] e_data;
    @(posedge clk);
    #1;
    cyc++;
    {e_sync, e_valid, e_eop, e_len, e_to} = '0;
    e_data = 8'h00;
    if (m_gnt >= 0) begin
      g = m_gnt;
      j = d_j;
      if (j >= 0 && j >= p_s[g]) begin
        n = j - p_s[g] + 1;
        m_synced = 1'b1;
        if (n <= 188) begin
          e_valid = 1'b1;
          e_data  = p_data[g][j];
          e_sync  = (n == 1);
          e_eop   = (n == 188) || (j == p_e[g]);
          e_len   = (n == 188 && j != p_e[g]) || (n < 188 && j == p_e[g]);
          if (n == 188) m_pkt++;
        end
        if (j == p_e[g]) end_grant(g);
      end else if (!m_synced) begin
        m_wait++;
        if (m_wait == STO) begin
          e_to = 1'b1;
          end_grant(g);
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (d_req != '0) begin
      g = -1;
      for (int k = 1; k <= NS; k++)
        if (g < 0 && d_req[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
      m_gnt = g; m_ptr = g; m_cur = g; m_wait = 0; m_synced = 1'b0; pos[g] = 0;
    end
    check_eq("ts", {ts_sync, ts_valid, ts_eop, ts_data}, {e_sync, e_valid, e_eop, e_data});
    check_eq("gnt", src_gnt, (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
    check_eq("cur_src", cur_src, m_cur);
    check_eq("err", {err_len, err_to}, {e_len, e_to});
    check_eq("pkt_cnt", pkt_cnt, m_pkt);
    if (err_len) cnt_len++;
    if (err_to) cnt_to++;
    if (prev_gnt == '0 && src_gnt != '0)
      for (int i = 0; i < NS; i++) if (src_gnt[i]) ord_q.push_back(i);
    prev_gnt = src_gnt;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = '0; src_sync = '0; src_eop = '0; src_data = '0; src_req = '0;
    m_gnt = -1; m_ptr = NS - 1; m_cur = 0; m_wait = 0; m_gap = 0; m_synced = 1'b0;
    m_pkt = 16'd0;
    prev_gnt = '0;
    ord_q.delete();
    cnt_len = 0;
    cnt_to = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  task automatic run_phase(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = (m_gnt < 0) && (npend[0] == 0) && (npend[1] == 0) && (npend[2] == 0)
             && (npend[3] == 0);
    end
    repeat (4) step();
    check_eq("phase_done", done, 1);
  endtask

  task automatic check_order();
    check_eq("order_len", ord_q.size(), exp_ord.size());
    for (int k = 0; k < exp_ord.size(); k++)
      check_eq($sformatf("order%0d", k), (k < ord_q.size()) ? ord_q[k] : 99, exp_ord[k]);
  endtask

  task automatic clear_src();
    for (int i = 0; i < NS; i++) set_src(i, 0, K_OK);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    src_req = '0; src_valid = '0; src_sync = '0; src_eop = '0; src_data = '0;

    // Sources 0 and 2 alternate.
    clear_src(); set_src(0, 2, K_OK); set_src(2, 2, K_OK);
    do_reset(); run_phase(4000);
    exp_ord = '{0, 2, 0, 2}; check_order();
    check_eq("p1_pkt_cnt", pkt_cnt, 4);
    check_eq("p1_err_len", cnt_len, 0);

    // All request, source 1 has a single packet.
    clear_src();
    for (int i = 0; i < NS; i++) set_src(i, (i == 1) ? 1 : 2, K_OK);
    do_reset(); run_phase(6000);
    exp_ord = '{0, 1, 2, 3, 0, 2, 3}; check_order();
    check_eq("p2_pkt_cnt", pkt_cnt, 7);

    // Short packet (eop at byte 100).
    clear_src(); set_src(0, 1, K_100); set_src(1, 1, K_OK);
    do_reset(); run_phase(3000);
    exp_ord = '{0, 1}; check_order();
    check_eq("p3_err_len", cnt_len, 1);
    check_eq("p3_pkt_cnt", pkt_cnt, 1);

    // Long packet (200 bytes) drained after byte 188.
    clear_src(); set_src(3, 1, K_200);
    do_reset(); run_phase(3000);
    exp_ord = '{3}; check_order();
    check_eq("p4_err_len", cnt_len, 1);
    check_eq("p4_pkt_cnt", pkt_cnt, 1);

    // Silent source times out, next source served.
    clear_src(); set_src(1, 1, K_TO); set_src(2, 1, K_OK);
    do_reset(); run_phase(3000);
    exp_ord = '{1, 2}; check_order();
    check_eq("p5_err_to", cnt_to, 1);
    check_eq("p5_pkt_cnt", pkt_cnt, 1);

    // Random mix of packet kinds.
    clear_src();
    for (int i = 0; i < NS; i++) begin
      npend[i] = $urandom_range(1, 4);
      kidx[i] = 0;
      for (int k = 0; k < npend[i]; k++) kind_tab[i][k] = $urandom_range(0, 3);
      gen_plan(i);
    end
    do_reset(); run_phase(30000);

    // Reset in the middle of source 2's second packet.
    clear_src(); set_src(2, 2, K_OK);
    do_reset();
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      step();
      hit = (m_gnt == 2) && (m_pkt == 16'd1) && (pos[2] >= 50);
    end
    check_eq("mid_reached", hit, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_ts", {ts_sync, ts_valid, ts_eop, ts_data}, 0);
    check_eq("rst_gnt", src_gnt, 0);
    check_eq("rst_cur", cur_src, 0);
    check_eq("rst_err", {err_len, err_to}, 0);
    check_eq("rst_pkt", pkt_cnt, 0);
    clear_src();
    for (int i = 0; i < NS; i++) set_src(i, 1, K_OK);
    do_reset(); run_phase(6000);
    exp_ord = '{0, 1, 2, 3}; check_order();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
